teclado_senha: RTL and testbench

Keypad entry stage sitting directly upstream of `acess_ctrl`. It collects decimal digit key strobes, builds an 8-bit password value (0–255), and on the confirm key presents it on `senha` one cycle before a single-cycle `enter` pulse. This matches the `senha_digitada`/`enter` contract `acess_ctrl` expects. Malformed entries are rejected locally with an `erro` pulse and never reach `acess_ctrl`.

---
 rtl/teclado_pkg.sv | 20 ++
 rtl/teclado_timer.sv | 35 +++
 rtl/teclado_senha.sv | 134 +++++++++++++
 tb/tb_teclado_senha.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// Shared key codes, FSM state type and entry limits for the keypad password stage.
package teclado_pkg;

   localparam logic [3:0] TECLA_LIMPA    = 4'hA;
   localparam logic [3:0] TECLA_CONFIRMA = 4'hB;

   localparam int         SENHA_MAX      = 255;
   localparam int         MAX_DIGITOS    = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COLETA = 2'd1,
      ENVIA  = 2'd2
   } estado_t;

   function automatic logic ehDigito(input logic [3:0] codigo);
      return codigo <= 4'd9;
   endfunction

endpackage

// File: rtl/teclado_timer.sv
// Idle counter for partial keypad entries; pulses expirou after TIMEOUT_CYCLES
// running cycles without a restart.
module teclado_timer #(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic restart,
   output logic expirou
);

   localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LIMITE = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] contador_q, contador_d;

   assign expirou = run && !restart && (contador_q == LIMITE);

   always_comb begin
      contador_d = contador_q + 1'b1;
      if (!run || restart || expirou) begin
         contador_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         contador_q <= '0;
      end else begin
         contador_q <= contador_d;
      end
   end

endmodule

// File: rtl/teclado_senha.sv
// Keypad entry stage: builds an 8-bit password from digit keys and hands it to
// acess_ctrl with senha set up one cycle before enter. Optional idle timeout: TECLADO_TIMEOUT_EN.
module teclado_senha
   import teclado_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [7:0] senha,
   output logic       enter,
   output logic       erro,
   output logic [1:0] n_digitos
);

   estado_t    estado_q, estado_d;
   logic [9:0] acc_q, acc_d;
   logic [1:0] cnt_q, cnt_d;
   logic [7:0] senha_q, senha_d;
   logic       erro_q, erro_d;
   logic       enter_q, enter_d;
   logic       expirou;

   logic ehTeclaDigito;
   logic ehTeclaValida;

   assign ehTeclaDigito = ehDigito(key_code);
   assign ehTeclaValida = ehTeclaDigito || (key_code == TECLA_LIMPA) || (key_code == TECLA_CONFIRMA);

`ifdef TECLADO_TIMEOUT_EN
   teclado_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (estado_q == COLETA),
      .restart (key_valid && ehTeclaValida),
      .expirou (expirou)
   );
`else
   // Constant-false; the term only keeps the parameter referenced in this build.
   assign expirou = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

   always_comb begin
      estado_d = estado_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      senha_d  = senha_q;
      erro_d   = 1'b0;
      enter_d  = 1'b0;

      case (estado_q)
         IDLE: begin
            if (key_valid) begin
               if (ehTeclaDigito) begin
                  acc_d    = {6'd0, key_code};
                  cnt_d    = 2'd1;
                  estado_d = COLETA;
               end else if (key_code == TECLA_CONFIRMA) begin
                  erro_d = 1'b1;
               end
            end
         end

         COLETA: begin
            if (key_valid && ehTeclaValida) begin
               acc_d    = '0;
               cnt_d    = '0;
               estado_d = IDLE;
               if (ehTeclaDigito) begin
                  if (cnt_q == 2'(MAX_DIGITOS)) begin
                     erro_d = 1'b1;
                  end else begin
                     acc_d    = acc_q * 10'd10 + {6'd0, key_code};
                     cnt_d    = cnt_q + 2'd1;
                     estado_d = COLETA;
                  end
               end else if (key_code == TECLA_CONFIRMA) begin
                  if (acc_q <= 10'(SENHA_MAX)) begin
                     senha_d  = acc_q[7:0];
                     estado_d = ENVIA;
                  end else begin
                     erro_d = 1'b1;
                  end
               end
            end else if (expirou) begin
               acc_d    = '0;
               cnt_d    = '0;
               erro_d   = 1'b1;
               estado_d = IDLE;
            end
         end

         ENVIA: begin
            // Keys arriving now are dropped; enter follows one cycle after senha.
            enter_d  = 1'b1;
            estado_d = IDLE;
         end

         default: begin
            acc_d    = '0;
            cnt_d    = '0;
            estado_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         senha_q  <= '0;
         erro_q   <= 1'b0;
         enter_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         senha_q  <= senha_d;
         erro_q   <= erro_d;
         enter_q  <= enter_d;
      end
   end

   assign senha     = senha_q;
   assign enter     = enter_q;
   assign erro      = erro_q;
   assign n_digitos = cnt_q;

endmodule

// File: tb/tb_teclado_senha.sv
// Directed self-checking bench for teclado_senha with a tiny acess_ctrl stand-in.
// Expectations for the idle-gap case follow TECLADO_TIMEOUT_EN.
module tb_teclado_senha;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       keyValid = 1'b0;
   logic [3:0] keyCode = 4'd0;
   logic [7:0] senha;
   logic       enter;
   logic       erro;
   logic [1:0] nDigitos;

   int checkCount = 0;
   int errorCount = 0;

   logic resultado = 1'b0;

   teclado_senha #(
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (keyValid),
      .key_code  (keyCode),
      .senha     (senha),
      .enter     (enter),
      .erro      (erro),
      .n_digitos (nDigitos)
   );

   always #5 clk = ~clk;

   // acess_ctrl stand-in: stored password is 146
   always @(posedge clk) begin
      if (enter) resultado <= (senha == 8'd146);
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] code);
      keyValid = 1'b1;
      keyCode  = code;
      @(posedge clk);
      #1;
      keyValid = 1'b0;
   endtask

   task automatic idleCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) idleCycle();
      checkOutput("reset_senha", senha, 0);
      checkOutput("reset_enter", enter, 0);
      checkOutput("reset_erro", erro, 0);
      checkOutput("reset_n", nDigitos, 0);
      rst = 1'b0;
      idleCycle();

      applyStimulus(4'd1);
      checkOutput("t1_n1", nDigitos, 1);
      applyStimulus(4'd4);
      checkOutput("t1_n2", nDigitos, 2);
      applyStimulus(4'd6);
      checkOutput("t1_n3", nDigitos, 3);
      applyStimulus(4'hB);
      checkOutput("t1_senha", senha, 146);
      checkOutput("t1_enter_early", enter, 0);
      checkOutput("t1_n0", nDigitos, 0);
      idleCycle();
      checkOutput("t1_enter", enter, 1);
      idleCycle();
      checkOutput("t1_enter_off", enter, 0);
      checkOutput("t1_resultado", resultado, 1);

      applyStimulus(4'd2);
      applyStimulus(4'd5);
      applyStimulus(4'd6);
      applyStimulus(4'hB);
      checkOutput("t2_erro", erro, 1);
      checkOutput("t2_senha", senha, 146);
      checkOutput("t2_n0", nDigitos, 0);
      idleCycle();
      checkOutput("t2_no_enter", enter, 0);
      checkOutput("t2_erro_off", erro, 0);

      applyStimulus(4'd1);
      applyStimulus(4'd2);
      applyStimulus(4'd3);
      checkOutput("t3_erro_pre", erro, 0);
      applyStimulus(4'd4);
      checkOutput("t3_erro_4th", erro, 1);
      checkOutput("t3_n0", nDigitos, 0);
      applyStimulus(4'hB);
      checkOutput("t3_erro_empty", erro, 1);
      idleCycle();
      checkOutput("t3_no_enter", enter, 0);

      applyStimulus(4'd9);
      applyStimulus(4'hC);
      checkOutput("t4_ignored_n", nDigitos, 1);
      checkOutput("t4_ignored_erro", erro, 0);
      applyStimulus(4'hA);
      checkOutput("t4_clear_n", nDigitos, 0);
      checkOutput("t4_clear_erro", erro, 0);
      applyStimulus(4'd1);
      applyStimulus(4'd9);
      applyStimulus(4'd9);
      applyStimulus(4'hB);
      checkOutput("t4_senha", senha, 199);
      applyStimulus(4'd5);
      checkOutput("t4_enter", enter, 1);
      checkOutput("t4_dropped_n", nDigitos, 0);
      idleCycle();
      checkOutput("t4_enter_off", enter, 0);
      checkOutput("t4_still_n0", nDigitos, 0);
      checkOutput("t4_resultado", resultado, 0);

      applyStimulus(4'd5);
      repeat (19) idleCycle();
      checkOutput("t5_before_limit_n", nDigitos, 1);
      checkOutput("t5_before_limit_erro", erro, 0);
      idleCycle();
`ifdef TECLADO_TIMEOUT_EN
      checkOutput("t5_timeout_erro", erro, 1);
      checkOutput("t5_timeout_n", nDigitos, 0);
`else
      checkOutput("t5_kept_erro", erro, 0);
      checkOutput("t5_kept_n", nDigitos, 1);
`endif
      applyStimulus(4'd8);
      applyStimulus(4'hB);
`ifdef TECLADO_TIMEOUT_EN
      checkOutput("t5_senha", senha, 8);
`else
      checkOutput("t5_senha", senha, 58);
`endif
      idleCycle();
      checkOutput("t5_enter", enter, 1);
      idleCycle();

      applyStimulus(4'd1);
      applyStimulus(4'd2);
      applyStimulus(4'hB);
      checkOutput("t6_senha_pre", senha, 12);
      rst      = 1'b1;
      keyValid = 1'b1;
      keyCode  = 4'd3;
      idleCycle();
      keyValid = 1'b0;
      checkOutput("t6_enter_cancel", enter, 0);
      checkOutput("t6_senha_reset", senha, 0);
      checkOutput("t6_n_reset", nDigitos, 0);
      rst = 1'b0;
      idleCycle();
      checkOutput("t6_enter_after", enter, 0);
      checkOutput("t6_n_after", nDigitos, 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
